alu_seq: RTL and testbench

Parametrised, registered ALU with a valid/ready handshake on both its input and its output. It generalises the team's 8-bit combinational ALU op set to WIDTH bits and adds status flags, illegal-op detection and a multi-cycle shift-add multiply. It sits between the decode/operand-fetch stage and writeback in the soft-core datapath.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_mul_seq.sv | 59 +++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings, flag struct, FSM states and flag helper shared by the ALU
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SLTU = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_XNOR = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_OR   = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_MUL  = 4'b1001,
    OP_SRA  = 4'b1101
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  function automatic alu_flags_t make_flags(input logic msb, input logic zero,
                                            input logic carry, input logic ovf);
    alu_flags_t f;
    f.n = msb;
    f.z = zero;
    f.c = carry;
    f.v = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle between the datapath and alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] n2;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s1;
  alu_flags_t       flags;
  logic             illegal_op;

  modport master (
    output in_valid, n1, n2, op, out_ready,
    input  in_ready, out_valid, s1, flags, illegal_op
  );

  modport slave (
    input  in_valid, n1, n2, op, out_ready,
    output in_ready, out_valid, s1, flags, illegal_op
  );

endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier, one partial product per cycle
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_cnt;
  logic               r_busy;

  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;

  // done/product present the final step's sum so the caller can register it on the same edge
  assign done    = r_busy && (r_cnt == CNT_LAST);
  assign product = w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with flags, illegal-op detection and sequential multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_AMT = WIDTH'(WIDTH);

  alu_state_e r_state;
  alu_state_e w_state_next;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_s1;
  alu_flags_t       r_flags;
  logic             r_illegal;

  logic w_in_ready;
  logic w_mul_start;
  logic w_load_alu;
  logic w_load_mul;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHW-1:0]     w_amt;
  logic               w_big;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_illegal;
  alu_flags_t         w_flags;
  alu_flags_t         w_mul_flags;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_sum  = {1'b0, bus.n1} + {1'b0, bus.n2};
  assign w_diff = bus.n1 - bus.n2;
  assign w_amt  = bus.n2[SHW-1:0];
  assign w_big  = (bus.n2 >= W_AMT);

  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.n1[WIDTH-1] == bus.n2[WIDTH-1]) && (w_sum[WIDTH-1] != bus.n1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff;
        w_carry = (bus.n1 < bus.n2);
        w_ovf   = (bus.n1[WIDTH-1] != bus.n2[WIDTH-1]) && (w_diff[WIDTH-1] != bus.n1[WIDTH-1]);
      end
      OP_SLL:  w_res = w_big ? '0 : (bus.n1 << w_amt);
      OP_SRL:  w_res = w_big ? '0 : (bus.n1 >> w_amt);
      OP_SRA:  w_res = w_big ? {WIDTH{bus.n1[WIDTH-1]}} : $unsigned($signed(bus.n1) >>> w_amt);
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.n1 < bus.n2)};
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.n1) < $signed(bus.n2))};
      OP_XNOR: w_res = ~(bus.n1 ^ bus.n2);
      OP_AND:  w_res = bus.n1 & bus.n2;
      OP_OR:   w_res = bus.n1 | bus.n2;
      OP_MUL:  w_res = '0;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_flags     = make_flags(w_res[WIDTH-1], (w_res == '0), w_carry, w_ovf);
  assign w_mul_flags = make_flags(w_prod[WIDTH-1], (w_prod[WIDTH-1:0] == '0),
                                  (w_prod[2*WIDTH-1:WIDTH] != '0), 1'b0);

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (w_mul_start),
    .a      (bus.n1),
    .b      (bus.n2),
    .done   (w_mul_done),
    .product(w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // out_ready feeds in_ready so a draining result slot can be refilled on the same edge
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_mul_start  = 1'b0;
    w_load_alu   = 1'b0;
    w_load_mul   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = !r_out_valid || bus.out_ready;
        if (bus.in_valid && w_in_ready) begin
          if (bus.op == OP_MUL) begin
            w_mul_start  = 1'b1;
            w_state_next = ST_MUL;
          end else begin
            w_load_alu = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_load_mul   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_s1        <= '0;
      r_flags     <= '0;
      r_illegal   <= 1'b0;
    end else if (w_load_alu) begin
      r_out_valid <= 1'b1;
      r_s1        <= w_res;
      r_flags     <= w_flags;
      r_illegal   <= w_illegal;
    end else if (w_load_mul) begin
      r_out_valid <= 1'b1;
      r_s1        <= w_prod[WIDTH-1:0];
      r_flags     <= w_mul_flags;
      r_illegal   <= 1'b0;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.s1         = r_s1;
  assign bus.flags      = r_flags;
  assign bus.illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=8 and WIDTH=16
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s1;
    logic [3:0] fl;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [15:0] s1;
    logic [3:0]  fl;
    logic        ill;
  } exp_t;

  localparam int NV = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q16[$];
  vec_t vecs[NV];

  alu_seq_if #(.WIDTH(8))  bus8 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic get_rdy(input bit wide);
    return wide ? bus16.in_ready : bus8.in_ready;
  endfunction

  function automatic logic get_ov(input bit wide);
    return wide ? bus16.out_valid : bus8.out_valid;
  endfunction

  task automatic drive(input bit wide, input logic v, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (wide) begin
      bus16.in_valid = v;
      bus16.op       = op;
      bus16.n1       = a;
      bus16.n2       = b;
    end else begin
      bus8.in_valid = v;
      bus8.op       = op;
      bus8.n1       = a[7:0];
      bus8.n2       = b[7:0];
    end
  endtask

  // called just after a rising edge; returns just after the accepting edge
  task automatic send(input bit wide, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] es1, input logic [3:0] efl,
                      input logic eill, input bit track, input bit keep, output int waited);
    logic r;
    bit   ok;
    exp_t e;
    drive(wide, 1'b1, op, a, b);
    waited = 0;
    ok = 0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      r = get_rdy(wide);
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%0h", op);
    end
    if (track) begin
      e.s1  = es1;
      e.fl  = efl;
      e.ill = eill;
      if (wide) q16.push_back(e);
      else q8.push_back(e);
    end
    if (!keep) drive(wide, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic mul_seq(input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] es1, input logic [3:0] efl);
    int w;
    int bad_rdy;
    int bad_ov;
    int waited;
    w = wide ? 16 : 8;
    bad_rdy = 0;
    bad_ov = 0;
    send(wide, OP_MUL, a, b, es1, efl, 1'b0, 1, 0, waited);
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      if (get_ov(wide)) bad_ov++;
      if (get_rdy(wide)) bad_rdy++;
      @(posedge clk);
    end
    #1;
    check($sformatf("mul%0d_early_valid", w), bad_ov, 0);
    check($sformatf("mul%0d_busy_ready", w), bad_rdy, 0);
    check($sformatf("mul%0d_latency", w), get_ov(wide), 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (q8.size() == 0 && q16.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    check("drain", q8.size() + q16.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out8 actual=%0h required=none", bus8.s1);
      end else begin
        e = q8.pop_front();
        check("out8_s1", bus8.s1, e.s1);
        check("out8_flags", bus8.flags, e.fl);
        check("out8_illegal", bus8.illegal_op, e.ill);
      end
    end
    if (!rst && bus16.out_valid && bus16.out_ready) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out16 actual=%0h required=none", bus16.s1);
      end else begin
        e = q16.pop_front();
        check("out16_s1", bus16.s1, e.s1);
        check("out16_flags", bus16.flags, e.fl);
        check("out16_illegal", bus16.illegal_op, e.ill);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int bad;

    vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0};
    vecs[1]  = '{OP_SUB,  8'h00, 8'h01, 8'hFF, 4'b1010, 1'b0};
    vecs[2]  = '{OP_SLL,  8'h01, 8'h08, 8'h00, 4'b0100, 1'b0};
    vecs[3]  = '{OP_SRA,  8'h80, 8'h09, 8'hFF, 4'b1000, 1'b0};
    vecs[4]  = '{OP_SRL,  8'h80, 8'h03, 8'h10, 4'b0000, 1'b0};
    vecs[5]  = '{OP_SLT,  8'hFF, 8'h01, 8'h01, 4'b0000, 1'b0};
    vecs[6]  = '{OP_SLTU, 8'hFF, 8'h01, 8'h00, 4'b0100, 1'b0};
    vecs[7]  = '{OP_XNOR, 8'hF0, 8'hCC, 8'hC3, 4'b1000, 1'b0};
    vecs[8]  = '{4'hF,    8'h12, 8'h34, 8'h00, 4'b0100, 1'b1};
    vecs[9]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0};
    vecs[10] = '{OP_OR,   8'h0F, 8'h30, 8'h3F, 4'b0000, 1'b0};
    vecs[11] = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0};
    vecs[12] = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b0001, 1'b0};
    vecs[13] = '{OP_SRA,  8'h80, 8'h03, 8'hF0, 4'b1000, 1'b0};
    vecs[14] = '{OP_SLL,  8'h81, 8'h01, 8'h02, 4'b0000, 1'b0};
    vecs[15] = '{OP_SRL,  8'h80, 8'hC8, 8'h00, 4'b0100, 1'b0};
    vecs[16] = '{4'hA,    8'h55, 8'hAA, 8'h00, 4'b0100, 1'b1};

    drive(0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1, 1'b0, 4'h0, 16'h0, 16'h0);
    bus8.out_ready  = 1'b1;
    bus16.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_s1", bus8.s1, 0);
    check("rst_flags", bus8.flags, 0);
    check("rst_illegal", bus8.illegal_op, 0);
    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_in_ready16", bus16.in_ready, 1);

    for (int i = 0; i < NV; i++) begin
      send(0, vecs[i].op, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, {8'h0, vecs[i].s1},
           vecs[i].fl, vecs[i].ill, 1, 0, waited);
      check($sformatf("lat1_v%0d", i), bus8.out_valid, 1);
    end

    mul_seq(0, 16'h10, 16'h11, 16'h10, 4'b0010);
    mul_seq(0, 16'h0F, 16'h0F, 16'hE1, 4'b1000);
    mul_seq(0, 16'hFF, 16'hFF, 16'h01, 4'b0010);
    drain();

    send(0, OP_ADD,  16'h10, 16'h20, 16'h30, 4'b0000, 1'b0, 1, 1, waited);
    check("b2b_wait0", waited, 0);
    send(0, OP_SUB,  16'h05, 16'h03, 16'h02, 4'b0000, 1'b0, 1, 1, waited);
    check("b2b_wait1", waited, 0);
    check("b2b_valid1", bus8.out_valid, 1);
    send(0, OP_OR,   16'h01, 16'h02, 16'h03, 4'b0000, 1'b0, 1, 1, waited);
    check("b2b_wait2", waited, 0);
    check("b2b_valid2", bus8.out_valid, 1);
    send(0, OP_AND,  16'hFF, 16'h0F, 16'h0F, 4'b0000, 1'b0, 1, 1, waited);
    check("b2b_wait3", waited, 0);
    send(0, OP_XNOR, 16'h00, 16'h00, 16'hFF, 4'b1000, 1'b0, 1, 0, waited);
    check("b2b_wait4", waited, 0);
    check("b2b_valid4", bus8.out_valid, 1);
    drain();

    bus8.out_ready = 1'b0;
    send(0, OP_ADD, 16'h03, 16'h04, 16'h07, 4'b0000, 1'b0, 1, 0, waited);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_s1", bus8.s1, 8'h07);
      check("bp_hold_valid", bus8.out_valid, 1);
      check("bp_hold_ready", bus8.in_ready, 0);
      @(posedge clk);
    end
    #1;
    bus8.out_ready = 1'b1;
    send(0, OP_AND, 16'hF0, 16'h3C, 16'h30, 4'b0000, 1'b0, 1, 0, waited);
    check("bp_refill_wait", waited, 0);
    check("bp_new_s1", bus8.s1, 8'h30);
    check("bp_new_valid", bus8.out_valid, 1);
    drain();

    send(0, OP_MUL, 16'h10, 16'h11, 16'h0, 4'b0, 1'b0, 0, 0, waited);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midmul_rst_ready", bus8.in_ready, 1);
    check("midmul_rst_valid", bus8.out_valid, 0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus8.out_valid) bad++;
    end
    @(posedge clk);
    #1;
    check("midmul_no_result", bad, 0);
    send(0, OP_ADD, 16'h01, 16'h01, 16'h02, 4'b0000, 1'b0, 1, 0, waited);
    check("post_rst_lat1", bus8.out_valid, 1);
    check("post_rst_s1", bus8.s1, 8'h02);
    drain();

    send(1, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0, 1, 0, waited);
    check("w16_lat1", bus16.out_valid, 1);
    send(1, OP_SRA, 16'h8000, 16'd16, 16'hFFFF, 4'b1000, 1'b0, 1, 0, waited);
    send(1, OP_SRA, 16'h4000, 16'd16, 16'h0000, 4'b0100, 1'b0, 1, 0, waited);
    mul_seq(1, 16'h0100, 16'h0100, 16'h0000, 4'b0110);
    mul_seq(1, 16'h00FF, 16'h0101, 16'hFFFF, 4'b1000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
